// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: parity mode codes, FSM state encoding, default line settings.
// Also intended for the companion uart_rx.
package uart_tx_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115200;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one LSB-first 8N/8O/8E frame (1 or 2 stop bits) per accepted byte.
// Start bit appears one cycle after acceptance; din_vld is ignored while tx_busy is high.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD      = DEF_BAUD,
  parameter int CHECK_BIT = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       tx_busy,
  output logic       tx
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD;
  localparam int CW       = (BAUD_CNT < 2) ? 1 : $clog2(BAUD_CNT);

  if (BAUD_CNT < 2 || CHECK_BIT < 0 || CHECK_BIT > 2 || STOP_BITS < 1 || STOP_BITS > 2)
  begin : g_bad_cfg
    $error("uart_tx: illegal configuration (BAUD_CNT < 2, CHECK_BIT or STOP_BITS out of range)");
  end

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt_baud, cnt_baud_nxt;
  logic [2:0]      cnt_bit, cnt_bit_nxt;
  logic            cnt_stop, cnt_stop_nxt;
  logic [7:0]      data, data_nxt;
  logic            tx_d;
  logic            busy_d;
  logic            bit_end;
  logic            par;

  assign bit_end = (cnt_baud == CW'(BAUD_CNT - 1));
  assign par     = (CHECK_BIT == PAR_ODD) ? ~^data : ^data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt_baud <= '0;
      cnt_bit  <= '0;
      cnt_stop <= 1'b0;
      data     <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_baud <= cnt_baud_nxt;
      cnt_bit  <= cnt_bit_nxt;
      cnt_stop <= cnt_stop_nxt;
      data     <= data_nxt;
      tx       <= tx_d;
      tx_busy  <= busy_d;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_baud_nxt = '0;
    cnt_bit_nxt  = cnt_bit;
    cnt_stop_nxt = cnt_stop;
    data_nxt     = data;
    tx_d         = 1'b1;

    if (state != S_IDLE && !bit_end)
      cnt_baud_nxt = cnt_baud + 1'b1;

    case (state)
      S_IDLE: begin
        if (din_vld) begin
          state_nxt = S_START;
          data_nxt  = din;
        end
      end
      S_START: begin
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (cnt_bit == 3'd7) begin
            cnt_bit_nxt = '0;
            state_nxt   = (CHECK_BIT != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            cnt_bit_nxt = cnt_bit + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        // cnt_stop only ever reaches 1 when two stop bits are configured
        if (bit_end) begin
          if (STOP_BITS == 2 && cnt_stop == 1'b0) begin
            cnt_stop_nxt = 1'b1;
          end else begin
            cnt_stop_nxt = 1'b0;
            state_nxt    = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Line level is decoded from the next state so tx is a plain flop output.
    case (state_nxt)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data[cnt_bit_nxt];
      S_PARITY: tx_d = par;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with BAUD_CNT=10: four instances cover no parity, even, odd and two stop bits.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din     [4];
  logic       din_vld [4];
  logic       tx      [4];
  logic       tx_busy [4];

  int checks   = 0;
  int failures = 0;

  logic [11:0] bits;
  int          busy_cyc;
  int          zero_cyc;
  int          stray;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(1000), .BAUD(100), .CHECK_BIT(0), .STOP_BITS(1)) u_none (
    .clk(clk), .rst_n(rst_n), .din(din[0]), .din_vld(din_vld[0]), .tx_busy(tx_busy[0]), .tx(tx[0]));
  uart_tx #(.CLK_FREQ(1000), .BAUD(100), .CHECK_BIT(2), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .din(din[1]), .din_vld(din_vld[1]), .tx_busy(tx_busy[1]), .tx(tx[1]));
  uart_tx #(.CLK_FREQ(1000), .BAUD(100), .CHECK_BIT(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .din(din[2]), .din_vld(din_vld[2]), .tx_busy(tx_busy[2]), .tx(tx[2]));
  uart_tx #(.CLK_FREQ(1000), .BAUD(100), .CHECK_BIT(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst_n(rst_n), .din(din[3]), .din_vld(din_vld[3]), .tx_busy(tx_busy[3]), .tx(tx[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; strobes din_vld for one cycle and returns in the first start-bit cycle.
  task automatic send(input int idx, input logic [7:0] b);
    din[idx]     = b;
    din_vld[idx] = 1'b1;
    @(negedge clk);
    din_vld[idx] = 1'b0;
  endtask

  // Samples each bit mid-slot, counts busy and low cycles; returns at the first negedge with busy low.
  task automatic capture(input int idx, input int nslots,
                         output logic [11:0] slots, output int nbusy, output int nzero);
    slots = '0;
    nbusy = 0;
    nzero = 0;
    for (int j = 0; j < 200; j++) begin
      if (tx_busy[idx] !== 1'b1) break;
      nbusy++;
      if (tx[idx] === 1'b0) nzero++;
      if (j % 10 == 5 && j / 10 < nslots) slots[j / 10] = tx[idx];
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din[i]     = 8'h00;
      din_vld[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_tx%0d", i), 32'(tx[i]), 32'd1);
      check($sformatf("reset_busy%0d", i), 32'(tx_busy[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0x55, no parity, one stop bit
    send(0, 8'h55);
    capture(0, 10, bits, busy_cyc, zero_cyc);
    check("x55_slots", 32'(bits), 32'({1'b1, 8'h55, 1'b0}));
    check("x55_busy", busy_cyc, 100);
    check("x55_low", zero_cyc, 50);
    repeat (3) @(negedge clk);

    // 0x07 with even then odd parity
    send(1, 8'h07);
    capture(1, 11, bits, busy_cyc, zero_cyc);
    check("even_slots", 32'(bits), 32'({1'b1, 1'b1, 8'h07, 1'b0}));
    check("even_busy", busy_cyc, 110);
    check("even_low", zero_cyc, 60);
    repeat (3) @(negedge clk);
    send(2, 8'h07);
    capture(2, 11, bits, busy_cyc, zero_cyc);
    check("odd_slots", 32'(bits), 32'({1'b1, 1'b0, 8'h07, 1'b0}));
    check("odd_busy", busy_cyc, 110);
    check("odd_low", zero_cyc, 70);
    repeat (3) @(negedge clk);

    // 0xA3 with a stray 0xFF strobe in mid-frame
    send(0, 8'hA3);
    fork
      capture(0, 10, bits, busy_cyc, zero_cyc);
      begin
        repeat (34) @(negedge clk);
        din[0]     = 8'hFF;
        din_vld[0] = 1'b1;
        @(negedge clk);
        din_vld[0] = 1'b0;
      end
    join
    check("ign_slots", 32'(bits), 32'({1'b1, 8'hA3, 1'b0}));
    check("ign_busy", busy_cyc, 100);
    check("ign_low", zero_cyc, 50);
    stray = 0;
    for (int j = 0; j < 30; j++) begin
      if (tx_busy[0] !== 1'b0 || tx[0] !== 1'b1) stray++;
      @(negedge clk);
    end
    check("ign_no_second_frame", stray, 0);

    // 0x12 then 0x34 back-to-back
    send(0, 8'h12);
    capture(0, 10, bits, busy_cyc, zero_cyc);
    check("b2b1_slots", 32'(bits), 32'({1'b1, 8'h12, 1'b0}));
    check("b2b1_busy", busy_cyc, 100);
    check("b2b_idle_tx", 32'(tx[0]), 32'd1);
    send(0, 8'h34);
    capture(0, 10, bits, busy_cyc, zero_cyc);
    check("b2b2_slots", 32'(bits), 32'({1'b1, 8'h34, 1'b0}));
    check("b2b2_busy", busy_cyc, 100);
    check("b2b2_low", zero_cyc, 60);
    repeat (3) @(negedge clk);

    // asynchronous reset during data bit 3 of 0xF0
    send(0, 8'hF0);
    repeat (43) @(negedge clk);
    check("rst_pre_tx", 32'(tx[0]), 32'd0);
    check("rst_pre_busy", 32'(tx_busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx[0]), 32'd1);
    check("rst_async_busy", 32'(tx_busy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h81);
    capture(0, 10, bits, busy_cyc, zero_cyc);
    check("post_rst_slots", 32'(bits), 32'({1'b1, 8'h81, 1'b0}));
    check("post_rst_busy", busy_cyc, 100);
    check("post_rst_low", zero_cyc, 70);
    repeat (3) @(negedge clk);

    // two stop bits
    send(3, 8'h00);
    capture(3, 11, bits, busy_cyc, zero_cyc);
    check("stop2_slots", 32'(bits), 32'({2'b11, 8'h00, 1'b0}));
    check("stop2_busy", busy_cyc, 110);
    check("stop2_low", zero_cyc, 90);
    check("stop2_idle_tx", 32'(tx[3]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
